// File: rtl/mmio_pkg.sv
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared register map and TCON bit layout for the timer MMIO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_ADDR = 32'h4000_0000;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_DIGI    = 5'h10;
    localparam logic [4:0] OFF_SYSTICK = 5'h14;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

endpackage

`default_nettype wire

// File: rtl/timer_core.sv
// ============================================================================
//  Module      : timer_core
//  Description : Reloadable 32-bit up-counter with overflow interrupt latch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_core
    import mmio_pkg::*;
(
    input  logic        slow_clk,
    input  logic        Reset,
    input  logic [31:0] wdata_i,
    input  logic        we_th_i,
    input  logic        we_tl_i,
    input  logic        we_tcon_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [2:0]  tcon_o,
    output logic        irq_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        ovf_w;
    logic        irq_set_w;

    assign ovf_w     = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    assign irq_set_w = ovf_w && tcon_q[TCON_IE];

    always_comb begin
        th_d   = we_th_i ? wdata_i : th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        // A TL store overrides both increment and reload; old TH feeds the reload.
        if (we_tl_i) begin
            tl_d = wdata_i;
        end else if (tcon_q[TCON_EN]) begin
            tl_d = ovf_w ? th_q : tl_q + 32'd1;
        end

        // The overflow set term is OR-ed in last so a concurrent TCON store can't drop it.
        if (we_tcon_i) begin
            tcon_d = wdata_i[2:0];
        end
        tcon_d[TCON_IS] = tcon_d[TCON_IS] | irq_set_w;
    end

    always_ff @(posedge slow_clk or posedge Reset) begin
        if (Reset) begin
            th_q   <= 32'h0;
            tl_q   <= 32'h0;
            tcon_q <= 3'b000;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;
    assign irq_o  = tcon_q[TCON_IS];

endmodule

`default_nettype wire

// File: rtl/mmio_timer_periph.sv
// ============================================================================
//  Module      : mmio_timer_periph
//  Description : Data-bus responder with timer, systick, LED and 7-seg regs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_timer_periph
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = MMIO_BASE_ADDR,
    parameter int          TICK_WIDTH = 32
) (
    input  logic        Reset,
    input  logic        slow_clk,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic [7:0]  led,
    output logic [10:0] digi,
    output logic        irq
);

    logic [29:0]           word_off_w;
    logic [2:0]            idx_w;
    logic                  hit_w;
    logic                  we_w;
    logic                  unused_addr_w;
    logic [7:0]            led_q, led_d;
    logic [10:0]           digi_q, digi_d;
    logic [TICK_WIDTH-1:0] systick_q;
    logic [31:0]           th_w, tl_w;
    logic [2:0]            tcon_w;
    logic                  irq_w;

    // Decode on word addresses so the byte lane bits never matter.
    assign word_off_w    = Address[31:2] - BASE_ADDR[31:2];
    assign idx_w         = word_off_w[2:0];
    assign hit_w         = (word_off_w[29:3] == 27'd0) && (idx_w <= OFF_SYSTICK[4:2]);
    assign we_w          = MemWrite && hit_w;
    assign unused_addr_w = ^Address[1:0];

    timer_core u_timer_core (
        .slow_clk  (slow_clk),
        .Reset     (Reset),
        .wdata_i   (Write_data),
        .we_th_i   (we_w && (idx_w == OFF_TH[4:2])),
        .we_tl_i   (we_w && (idx_w == OFF_TL[4:2])),
        .we_tcon_i (we_w && (idx_w == OFF_TCON[4:2])),
        .th_o      (th_w),
        .tl_o      (tl_w),
        .tcon_o    (tcon_w),
        .irq_o     (irq_w)
    );

    always_comb begin
        led_d  = led_q;
        digi_d = digi_q;
        if (we_w && (idx_w == OFF_LED[4:2])) begin
            led_d = Write_data[7:0];
        end
        if (we_w && (idx_w == OFF_DIGI[4:2])) begin
            digi_d = Write_data[10:0];
        end
    end

    always_ff @(posedge slow_clk or posedge Reset) begin
        if (Reset) begin
            led_q     <= 8'h0;
            digi_q    <= 11'h0;
            systick_q <= '0;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_q + TICK_WIDTH'(1);
        end
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead && hit_w) begin
            case (idx_w)
                OFF_TH[4:2]:      Read_data = th_w;
                OFF_TL[4:2]:      Read_data = tl_w;
                OFF_TCON[4:2]:    Read_data = {29'h0, tcon_w};
                OFF_LED[4:2]:     Read_data = {24'h0, led_q};
                OFF_DIGI[4:2]:    Read_data = {21'h0, digi_q};
                OFF_SYSTICK[4:2]: Read_data = 32'(systick_q);
                default:          Read_data = 32'h0;
            endcase
        end
    end

    assign hit  = hit_w;
    assign led  = led_q;
    assign digi = digi_q;
    assign irq  = irq_w;

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer_periph.sv
// ============================================================================
//  Module      : tb_mmio_timer_periph
//  Description : Directed scoreboard bench for the timer MMIO peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_timer_periph;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic        Reset;
    logic        slow_clk;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        hit;
    logic [7:0]  led;
    logic [10:0] digi;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    mmio_timer_periph dut (
        .Reset      (Reset),
        .slow_clk   (slow_clk),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .led        (led),
        .digi       (digi),
        .irq        (irq)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic tick();
        @(posedge slow_clk);
        #1;
        cyc++;
    endtask

    task automatic push(input string tag, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t item;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: observed %h required an expectation", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.exp) n_pass++;
            else $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] e, input string tag);
        push(tag, e);
        Address = addr;
        MemRead = 1'b1;
        #1;
        check(Read_data);
        MemRead = 1'b0;
    endtask

    task automatic sig(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push(tag, e);
        check(obs);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        tick();
        MemWrite   = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        Address    = 32'h0;
        Write_data = 32'h0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        repeat (2) @(posedge slow_clk);
        #1;
        Reset = 1'b0;
        cyc   = 0;

        // Reset state and systick alignment
        repeat (10) tick();
        rd(A_TICK, 32'(cyc), "systick_10");
        rd(A_TH,   32'h0, "rst_th");
        rd(A_TL,   32'h0, "rst_tl");
        rd(A_TCON, 32'h0, "rst_tcon");
        rd(A_LED,  32'h0, "rst_led");
        rd(A_DIGI, 32'h0, "rst_digi");
        sig("rst_irq", 32'(irq), 32'h0);

        // Overflow with irq enabled
        wr(A_TH,   32'hFFFF_FFFC);
        wr(A_TL,   32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        tick();
        rd(A_TL, 32'hFFFF_FFFF, "tl_ff");
        sig("irq_pre_ovf", 32'(irq), 32'h0);
        tick();
        rd(A_TL, 32'hFFFF_FFFC, "tl_reload");
        sig("irq_set", 32'(irq), 32'h1);
        tick();
        rd(A_TL, 32'hFFFF_FFFD, "tl_after_reload");

        // Software clear, then clear collides with overflow
        wr(A_TCON, 32'h3);
        sig("irq_cleared", 32'(irq), 32'h0);
        tick();
        rd(A_TL, 32'hFFFF_FFFF, "tl_ff2");
        wr(A_TCON, 32'h3);
        sig("irq_kept_on_ovf", 32'(irq), 32'h1);
        rd(A_TL, 32'hFFFF_FFFC, "tl_reload2");

        // irq disabled: reload without interrupt, then TL store mid-count
        wr(A_TCON, 32'h1);
        sig("irq_off", 32'(irq), 32'h0);
        rd(A_TCON, 32'h1, "tcon_1");
        tick();
        tick();
        rd(A_TL, 32'hFFFF_FFFF, "tl_ff3");
        tick();
        rd(A_TL, 32'hFFFF_FFFC, "tl_reload_noie");
        sig("irq_stays_0", 32'(irq), 32'h0);
        wr(A_TL, 32'h5);
        rd(A_TL, 32'h5, "tl_write_wins");
        tick();
        rd(A_TL, 32'h6, "tl_count_on");

        // LED/DIGI truncation, systick is read-only
        wr(A_LED,  32'h1234_56A5);
        wr(A_DIGI, 32'hFFFF_F7FF);
        sig("led_out",  32'(led),  32'hA5);
        sig("digi_out", 32'(digi), 32'h7FF);
        rd(A_LED,  32'hA5,  "led_rd");
        rd(A_DIGI, 32'h7FF, "digi_rd");
        wr(A_TICK, 32'h0);
        rd(A_TICK, 32'(cyc), "systick_ro");

        // Read and write in the same cycle returns the old value
        Address    = A_LED;
        Write_data = 32'h3C;
        MemRead    = 1'b1;
        MemWrite   = 1'b1;
        #1;
        sig("rdwr_old", Read_data, 32'hA5);
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        sig("rdwr_new", 32'(led), 32'h3C);

        // Decode boundaries
        rd(32'h4000_000F, 32'h3C, "byte_lane_ignored");
        sig("hit_in", 32'(hit), 32'h1);
        rd(32'h4000_0018, 32'h0, "unused_off_rd");
        sig("hit_unused", 32'(hit), 32'h0);
        rd(32'h1000_0000, 32'h0, "outside_rd");
        sig("hit_outside", 32'(hit), 32'h0);
        wr(32'h4000_0018, 32'hFF);
        wr(32'h1000_000C, 32'hFF);
        sig("led_no_change", 32'(led), 32'h3C);

        // Asynchronous reset in the middle of a cycle with irq pending
        wr(A_TCON, 32'h3);
        wr(A_TL,   32'hFFFF_FFFF);
        tick();
        sig("irq_before_rst", 32'(irq), 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        sig("rst_async_irq",  32'(irq),  32'h0);
        sig("rst_async_led",  32'(led),  32'h0);
        sig("rst_async_digi", 32'(digi), 32'h0);
        rd(A_TL, 32'h0, "rst_async_tl");
        @(posedge slow_clk);
        #1;
        Reset = 1'b0;
        cyc   = 0;
        repeat (3) tick();
        rd(A_TL,   32'h0,     "timer_stopped");
        rd(A_TICK, 32'(cyc),  "systick_restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
